// File: rtl/sprite_test_core.sv
// ============================================================================
// Module      : sprite_test_core
// Description : Overlays a constant 4x4 sprite onto the VGA scan. The hit test
//               and sprite ROM lookup are combinational. The resulting colour
//               is held in a single output register, so pixel follows its
//               inputs by one clock.
//               Optional feature: define SPRITE_TRANSPARENCY_EN so that ROM
//               entries of 3'b000 show the background colour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_test_core #(
  parameter logic [2:0] BG_COLOR = 3'b001
) (
  input  logic       VGA_CLK,
  input  logic       resetn,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [7:0] xvga,
  input  logic [6:0] yvga,
  output logic [2:0] pixel
);

  // One column and one row past the sprite. They are computed one bit wider
  // so that a sprite at the right or bottom edge is clipped, not wrapped.
  logic [8:0] x_end;
  logic [7:0] y_end;
  logic       hit;
  logic [1:0] dx;
  logic [1:0] dy;
  logic [2:0] rom_color;
  logic [2:0] next_pixel;

  assign x_end = {1'b0, x} + 9'd4;
  assign y_end = {1'b0, y} + 8'd4;

  assign hit = (xvga >= x) && ({1'b0, xvga} < x_end) &&
               (yvga >= y) && ({1'b0, yvga} < y_end);

  // On a hit the offset is 0..3, so only the low two bits of the difference
  // are needed.
  assign dx = xvga[1:0] - x[1:0];
  assign dy = yvga[1:0] - y[1:0];

  // Sprite ROM, indexed by dy*4+dx: a ring of 7 with a 4 centre and 0 corners
  always_comb begin
    rom_color = 3'd0;
    case ({dy, dx})
      4'd0, 4'd3, 4'd12, 4'd15: rom_color = 3'd0;
      4'd5, 4'd6, 4'd9,  4'd10: rom_color = 3'd4;
      default:                  rom_color = 3'd7;
    endcase
  end

  // Choose the sprite colour on a hit and the background colour otherwise
  always_comb begin
    next_pixel = BG_COLOR;
    if (hit) begin
`ifdef SPRITE_TRANSPARENCY_EN
      if (rom_color != 3'd0) begin
        next_pixel = rom_color;
      end
`else
      next_pixel = rom_color;
`endif
    end
  end

  // Output register. This is the only storage in the block.
  always_ff @(posedge VGA_CLK or negedge resetn) begin
    if (!resetn) begin
      pixel <= 3'b000;
    end else begin
      pixel <= next_pixel;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sprite_test_core.sv
// ============================================================================
// Module      : tb_sprite_test_core
// Description : Self-checking bench for sprite_test_core. It runs directed
//               scans (reset, corners, interior, boundary, edge clipping and
//               a reset in the middle of a scan) and then random scans, which
//               are compared with a behavioural model of the sprite.
//               Honours SPRITE_TRANSPARENCY_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_test_core;

  localparam logic [2:0] BG = 3'b001;

`ifdef SPRITE_TRANSPARENCY_EN
  localparam logic [2:0] CORNER = BG;
`else
  localparam logic [2:0] CORNER = 3'b000;
`endif

  logic       VGA_CLK = 1'b0;
  logic       resetn  = 1'b1;
  logic [7:0] x       = 8'd0;
  logic [6:0] y       = 7'd0;
  logic [7:0] xvga    = 8'd0;
  logic [6:0] yvga    = 7'd0;
  logic [2:0] pixel;

  int vectors    = 0;
  int miscompares = 0;

  // The sprite image, stored as rows of the picture
  int sprite [4][4] = '{'{0, 7, 7, 0},
                        '{7, 4, 4, 7},
                        '{7, 4, 4, 7},
                        '{0, 7, 7, 0}};

  sprite_test_core #(.BG_COLOR(BG)) dut (
    .VGA_CLK(VGA_CLK),
    .resetn (resetn),
    .x      (x),
    .y      (y),
    .xvga   (xvga),
    .yvga   (yvga),
    .pixel  (pixel)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  // Colour expected at scan (sx,sy) when the sprite's top-left corner is
  // at (px,py). The arithmetic is done on plain integers, so a sprite near
  // the edge of the screen cannot wrap.
  function automatic logic [2:0] model(int px, int py, int sx, int sy);
    int v;
    if (sx >= px && sx < px + 4 && sy >= py && sy < py + 4) begin
      v = sprite[sy - py][sx - px];
`ifdef SPRITE_TRANSPARENCY_EN
      if (v == 0) v = int'(BG);
`endif
      return v[2:0];
    end
    return BG;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one scan position away from the clock edge, then sample 1ns after
  // the next rising edge.
  task automatic scan(input logic [7:0] px, input logic [6:0] py,
                      input logic [7:0] sx, input logic [6:0] sy);
    @(negedge VGA_CLK);
    x    = px;
    y    = py;
    xvga = sx;
    yvga = sy;
    @(posedge VGA_CLK);
    #1;
  endtask

  initial begin
    logic [7:0] rx, rsx;
    logic [6:0] ry, rsy;

    // Reset while the inputs point inside the sprite. The output must clear
    // at once and must stay clear across clock edges.
    x = 8'd4; y = 7'd16; xvga = 8'd5; yvga = 7'd16;
    #2 resetn = 1'b0;
    #1 check("reset_async", pixel, 3'b000);
    repeat (2) @(posedge VGA_CLK);
    #1 check("reset_held", pixel, 3'b000);
    @(negedge VGA_CLK);
    resetn = 1'b1;

    scan(8'd4, 7'd16, 8'd0, 7'd16 - 7'd16);
    check("first_after_reset", pixel, 3'b001);

    // The top-left and bottom-right corners
    scan(8'd4, 7'd16, 8'd4, 7'd16);
    check("corner_tl", pixel, CORNER);
    scan(8'd4, 7'd16, 8'd7, 7'd19);
    check("corner_br", pixel, CORNER);

    // Interior of the sprite
    scan(8'd4, 7'd16, 8'd5, 7'd16);
    check("interior_5_16", pixel, 3'b111);
    scan(8'd4, 7'd16, 8'd5, 7'd17);
    check("interior_5_17", pixel, 3'b100);
    scan(8'd4, 7'd16, 8'd7, 7'd17);
    check("interior_7_17", pixel, 3'b111);

    // Positions just outside the sprite
    scan(8'd4, 7'd16, 8'd8, 7'd20);
    check("bound_8_20", pixel, 3'b001);
    scan(8'd4, 7'd16, 8'd8, 7'd17);
    check("bound_8_17", pixel, 3'b001);
    scan(8'd4, 7'd16, 8'd5, 7'd20);
    check("bound_5_20", pixel, 3'b001);
    scan(8'd4, 7'd16, 8'd3, 7'd16);
    check("bound_3_16", pixel, 3'b001);

    // A sprite at the bottom-right edge is clipped, not wrapped
    scan(8'd254, 7'd126, 8'd255, 7'd127);
    check("clip_255_127", pixel, 3'b100);
    scan(8'd254, 7'd126, 8'd0, 7'd0);
    check("clip_0_0", pixel, 3'b001);
    scan(8'd254, 7'd126, 8'd1, 7'd127);
    check("clip_1_127", pixel, 3'b001);

    // A new sprite position takes effect at the very next edge
    scan(8'd100, 7'd50, 8'd5, 7'd16);
    check("move_away", pixel, 3'b001);

    // Reset in the middle of a scan
    scan(8'd4, 7'd16, 8'd5, 7'd16);
    check("midscan_before", pixel, 3'b111);
    #2 resetn = 1'b0;
    #1 check("midscan_reset", pixel, 3'b000);
    @(negedge VGA_CLK);
    resetn = 1'b1;
    @(posedge VGA_CLK);
    #1 check("midscan_resume", pixel, 3'b111);

    // Random scans, mostly near the sprite so that both hits and misses occur
    for (int i = 0; i < 300; i++) begin
      rx  = 8'($urandom);
      ry  = 7'($urandom);
      rsx = rx + 8'($urandom_range(0, 6)) - 8'd1;
      rsy = ry + 7'($urandom_range(0, 6)) - 7'd1;
      if ($urandom_range(0, 7) == 0) rsx = 8'($urandom);
      if ($urandom_range(0, 7) == 0) rsy = 7'($urandom);
      scan(rx, ry, rsx, rsy);
      check("random", pixel, model(int'(rx), int'(ry), int'(rsx), int'(rsy)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Stops the run if the main sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: observed stall, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
